// File: rtl/logic_rs_sched.sv
// Reservation-station scheduler for a shared combinational logic unit.
// Entries wake on CDB broadcasts; the oldest ready entry dispatches.
module logic_rs_sched #(
    parameter int NUM_RS = 4,
    parameter int TAG_W  = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        ISSUE_VALID,
    output logic                        ISSUE_READY,
    input  logic [2:0]                  ISSUE_OP,
    input  logic [TAG_W-1:0]            ISSUE_TAG,
    input  logic [31:0]                 ISSUE_V1,
    input  logic [31:0]                 ISSUE_V2,
    input  logic [TAG_W-1:0]            ISSUE_Q1,
    input  logic [TAG_W-1:0]            ISSUE_Q2,
    input  logic                        CDB_IN_VALID,
    input  logic [TAG_W-1:0]            CDB_IN_TAG,
    input  logic [31:0]                 CDB_IN_DATA,
    output logic [2:0]                  LU_OP,
    output logic [31:0]                 LU_IN1,
    output logic [31:0]                 LU_IN2,
    input  logic [31:0]                 LU_OUT,
    output logic                        RES_VALID,
    input  logic                        RES_READY,
    output logic [TAG_W-1:0]            RES_TAG,
    output logic [31:0]                 RES_DATA,
    output logic [$clog2(NUM_RS+1)-1:0] BUSY_COUNT
);
    localparam int CNT_W = $clog2(NUM_RS + 1);
    localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [NUM_RS-1:0] r_busy;
    logic [2:0]        r_op  [NUM_RS];
    logic [TAG_W-1:0]  r_tag [NUM_RS];
    logic [31:0]       r_v1  [NUM_RS];
    logic [31:0]       r_v2  [NUM_RS];
    logic [TAG_W-1:0]  r_q1  [NUM_RS];
    logic [TAG_W-1:0]  r_q2  [NUM_RS];
    // age = number of older busy entries, so ages are always distinct
    logic [IDX_W-1:0]  r_age [NUM_RS];

    logic [0:0]        r_state;
    logic [TAG_W-1:0]  r_res_tag;
    logic [31:0]       r_res_data;
    logic [2:0]        r_lu_op;
    logic [31:0]       r_lu_in1;
    logic [31:0]       r_lu_in2;

    logic [NUM_RS-1:0] w_rdy;
    logic              w_free_found;
    logic [IDX_W-1:0]  w_free_idx;
    logic              w_sel_found;
    logic [IDX_W-1:0]  w_sel_idx;
    logic [IDX_W-1:0]  w_sel_age;
    logic [CNT_W-1:0]  w_cnt;
    logic [CNT_W-1:0]  w_new_age;
    logic              w_issue;
    logic              w_disp;
    logic              w_byp1;
    logic              w_byp2;

    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_cnt        = '0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_RS; i++) begin
            w_cnt = w_cnt + CNT_W'(r_busy[i]);
        end
    end

    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_sel_age   = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            w_rdy[i] = r_busy[i] && (r_q1[i] == '0) && (r_q2[i] == '0);
            if (w_rdy[i] && (!w_sel_found || r_age[i] < w_sel_age)) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
                w_sel_age   = r_age[i];
            end
        end
    end

    assign ISSUE_READY = !RST && w_free_found;
    assign w_issue     = ISSUE_VALID && ISSUE_READY;
    assign w_disp      = !RST && w_sel_found &&
                         (r_state == S_IDLE || RES_READY);
    assign w_new_age   = w_cnt - CNT_W'(w_disp);

    assign w_byp1 = CDB_IN_VALID && (ISSUE_Q1 != '0) &&
                    (CDB_IN_TAG == ISSUE_Q1);
    assign w_byp2 = CDB_IN_VALID && (ISSUE_Q2 != '0) &&
                    (CDB_IN_TAG == ISSUE_Q2);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_RS; i++) begin
                r_busy[i] <= 1'b0;
                r_age[i]  <= '0;
                r_op[i]   <= '0;
                r_tag[i]  <= '0;
                r_v1[i]   <= '0;
                r_v2[i]   <= '0;
                r_q1[i]   <= '0;
                r_q2[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RS; i++) begin
                if (r_busy[i]) begin
                    if (w_disp && w_sel_idx == IDX_W'(i)) begin
                        r_busy[i] <= 1'b0;
                    end else begin
                        if (CDB_IN_VALID && r_q1[i] != '0 &&
                            r_q1[i] == CDB_IN_TAG) begin
                            r_v1[i] <= CDB_IN_DATA;
                            r_q1[i] <= '0;
                        end
                        if (CDB_IN_VALID && r_q2[i] != '0 &&
                            r_q2[i] == CDB_IN_TAG) begin
                            r_v2[i] <= CDB_IN_DATA;
                            r_q2[i] <= '0;
                        end
                        if (w_disp && r_age[i] > w_sel_age) begin
                            r_age[i] <= r_age[i] - 1'b1;
                        end
                    end
                end else if (w_issue && w_free_idx == IDX_W'(i)) begin
                    r_busy[i] <= 1'b1;
                    r_op[i]   <= ISSUE_OP;
                    r_tag[i]  <= ISSUE_TAG;
                    r_age[i]  <= IDX_W'(w_new_age);
                    r_v1[i]   <= w_byp1 ? CDB_IN_DATA : ISSUE_V1;
                    r_q1[i]   <= w_byp1 ? '0 : ISSUE_Q1;
                    r_v2[i]   <= w_byp2 ? CDB_IN_DATA : ISSUE_V2;
                    r_q2[i]   <= w_byp2 ? '0 : ISSUE_Q2;
                end
            end
        end
    end

    assign LU_OP  = w_disp ? r_op[w_sel_idx] : r_lu_op;
    assign LU_IN1 = w_disp ? r_v1[w_sel_idx] : r_lu_in1;
    assign LU_IN2 = w_disp ? r_v2[w_sel_idx] : r_lu_in2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_res_tag  <= '0;
            r_res_data <= '0;
            r_lu_op    <= '0;
            r_lu_in1   <= '0;
            r_lu_in2   <= '0;
        end else if (w_disp) begin
            r_state    <= S_HOLD;
            r_res_tag  <= r_tag[w_sel_idx];
            r_res_data <= LU_OUT;
            r_lu_op    <= LU_OP;
            r_lu_in1   <= LU_IN1;
            r_lu_in2   <= LU_IN2;
        end else if (r_state == S_HOLD && RES_READY) begin
            r_state    <= S_IDLE;
        end
    end

    assign RES_VALID  = (r_state == S_HOLD);
    assign RES_TAG    = r_res_tag;
    assign RES_DATA   = r_res_data;
    assign BUSY_COUNT = w_cnt;

endmodule

// File: tb/tb_logic_rs_sched.sv
// Scoreboard bench for logic_rs_sched: expected results queued at issue,
// matched by tag when the result handshake completes.
module tb_logic_rs_sched;
    logic        CLK;
    logic        RST;
    logic        ISSUE_VALID;
    logic        ISSUE_READY;
    logic [2:0]  ISSUE_OP;
    logic [3:0]  ISSUE_TAG;
    logic [31:0] ISSUE_V1;
    logic [31:0] ISSUE_V2;
    logic [3:0]  ISSUE_Q1;
    logic [3:0]  ISSUE_Q2;
    logic        CDB_IN_VALID;
    logic [3:0]  CDB_IN_TAG;
    logic [31:0] CDB_IN_DATA;
    logic [2:0]  LU_OP;
    logic [31:0] LU_IN1;
    logic [31:0] LU_IN2;
    logic [31:0] LU_OUT;
    logic        RES_VALID;
    logic        RES_READY;
    logic [3:0]  RES_TAG;
    logic [31:0] RES_DATA;
    logic [2:0]  BUSY_COUNT;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   n_chk;
    int   n_pass;
    logic [31:0] held_data;

    logic_rs_sched #(.NUM_RS(4), .TAG_W(4)) dut (
        .CLK(CLK), .RST(RST),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_READY(ISSUE_READY),
        .ISSUE_OP(ISSUE_OP), .ISSUE_TAG(ISSUE_TAG),
        .ISSUE_V1(ISSUE_V1), .ISSUE_V2(ISSUE_V2),
        .ISSUE_Q1(ISSUE_Q1), .ISSUE_Q2(ISSUE_Q2),
        .CDB_IN_VALID(CDB_IN_VALID), .CDB_IN_TAG(CDB_IN_TAG),
        .CDB_IN_DATA(CDB_IN_DATA),
        .LU_OP(LU_OP), .LU_IN1(LU_IN1), .LU_IN2(LU_IN2), .LU_OUT(LU_OUT),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY),
        .RES_TAG(RES_TAG), .RES_DATA(RES_DATA),
        .BUSY_COUNT(BUSY_COUNT)
    );

    function automatic logic [31:0] lu_model(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a ^ b);
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    always_comb LU_OUT = lu_model(LU_OP, LU_IN1, LU_IN2);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // e1/e2 are the operand values the entry will finally compute with
    task automatic do_issue(input logic [2:0] op, input logic [3:0] tag,
                            input logic [31:0] v1, input logic [3:0] q1,
                            input logic [31:0] v2, input logic [3:0] q2,
                            input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        ISSUE_VALID = 1'b1;
        ISSUE_OP    = op;
        ISSUE_TAG   = tag;
        ISSUE_V1    = v1;
        ISSUE_Q1    = q1;
        ISSUE_V2    = v2;
        ISSUE_Q2    = q2;
        if (ISSUE_READY) begin
            e.tag  = tag;
            e.data = lu_model(op, e1, e2);
            q.push_back(e);
        end
        tick();
        ISSUE_VALID = 1'b0;
    endtask

    task automatic cdb(input logic v, input logic [3:0] t,
                       input logic [31:0] d);
        CDB_IN_VALID = v;
        CDB_IN_TAG   = t;
        CDB_IN_DATA  = d;
    endtask

    always @(negedge CLK) begin
        int idx;
        if (!RST && RES_VALID && RES_READY) begin
            idx = -1;
            for (int i = 0; i < q.size(); i++) begin
                if (idx < 0 && q[i].tag == RES_TAG) idx = i;
            end
            chk("sb_hit", idx >= 0, 1);
            if (idx >= 0) begin
                chk("sb_data", RES_DATA, q[idx].data);
                q.delete(idx);
            end
        end
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        RST = 1'b1;
        ISSUE_VALID = 1'b0;
        ISSUE_OP = '0;
        ISSUE_TAG = '0;
        ISSUE_V1 = '0;
        ISSUE_V2 = '0;
        ISSUE_Q1 = '0;
        ISSUE_Q2 = '0;
        RES_READY = 1'b1;
        cdb(1'b0, 4'd0, 32'd0);
        tick();
        tick();
        chk("rst_irdy", ISSUE_READY, 0);
        chk("rst_rvalid", RES_VALID, 0);
        chk("rst_busy", BUSY_COUNT, 0);
        chk("rst_luop", LU_OP, 0);
        chk("rst_rdata", RES_DATA, 0);
        RST = 1'b0;
        tick();
        chk("irdy_after_rst", ISSUE_READY, 1);

        // XNOR, both operands ready
        do_issue(3'd3, 4'd3, 32'hFFFF0000, 4'd0, 32'hFF00FF00, 4'd0,
                 32'hFFFF0000, 32'hFF00FF00);
        chk("xnor_t1_valid", RES_VALID, 0);
        chk("xnor_t1_busy", BUSY_COUNT, 1);
        tick();
        chk("xnor_t2_valid", RES_VALID, 1);
        chk("xnor_tag", RES_TAG, 3);
        chk("xnor_data", RES_DATA, 32'hFF0000FF);
        tick();
        chk("xnor_idle", RES_VALID, 0);

        // AND waiting on tag 7
        do_issue(3'd0, 4'd5, 32'h0, 4'd7, 32'hFFFFFFFF, 4'd0,
                 32'h0F0F0F0F, 32'hFFFFFFFF);
        tick();
        cdb(1'b1, 4'd7, 32'h0F0F0F0F);
        tick();
        cdb(1'b0, 4'd0, 32'd0);
        chk("wake_c1_valid", RES_VALID, 0);
        tick();
        chk("wake_c2_valid", RES_VALID, 1);
        chk("wake_tag", RES_TAG, 5);
        chk("wake_data", RES_DATA, 32'h0F0F0F0F);
        tick();

        // same-cycle CDB bypass on issue
        cdb(1'b1, 4'd9, 32'h12345600);
        do_issue(3'd1, 4'd6, 32'hDEADBEEF, 4'd9, 32'h000000F0, 4'd0,
                 32'h12345600, 32'h000000F0);
        cdb(1'b0, 4'd0, 32'd0);
        chk("byp_t1_valid", RES_VALID, 0);
        tick();
        chk("byp_valid", RES_VALID, 1);
        chk("byp_tag", RES_TAG, 6);
        chk("byp_data", RES_DATA, 32'h123456F0);
        tick();

        // fill all entries waiting on tag 10
        do_issue(3'd4, 4'd1, 32'h0, 4'd10, 32'h0F0F0F0F, 4'd0,
                 32'h5A5AA5A5, 32'h0F0F0F0F);
        do_issue(3'd5, 4'd2, 32'h0, 4'd10, 32'h0F0F0F0F, 4'd0,
                 32'h5A5AA5A5, 32'h0F0F0F0F);
        do_issue(3'd6, 4'd3, 32'h0, 4'd10, 32'h0F0F0F0F, 4'd0,
                 32'h5A5AA5A5, 32'h0F0F0F0F);
        do_issue(3'd7, 4'd4, 32'h0, 4'd10, 32'h0F0F0F0F, 4'd0,
                 32'h5A5AA5A5, 32'h0F0F0F0F);
        chk("full_busy", BUSY_COUNT, 4);
        chk("full_irdy", ISSUE_READY, 0);
        do_issue(3'd0, 4'd11, 32'h1, 4'd0, 32'h1, 4'd0, 32'h1, 32'h1);
        chk("full_reject", BUSY_COUNT, 4);
        cdb(1'b1, 4'd10, 32'h5A5AA5A5);
        tick();
        cdb(1'b0, 4'd0, 32'd0);
        chk("full_wake_valid", RES_VALID, 0);
        tick();
        chk("full_free_busy", BUSY_COUNT, 3);
        chk("full_free_irdy", ISSUE_READY, 1);
        chk("order_tag1", RES_TAG, 1);
        tick();
        chk("order_tag2", RES_TAG, 2);
        tick();
        chk("order_tag3", RES_TAG, 3);
        tick();
        chk("order_tag4", RES_TAG, 4);
        chk("drain_busy", BUSY_COUNT, 0);
        tick();
        chk("drain_idle", RES_VALID, 0);

        // age vs index: youngest entry reuses slot 0
        do_issue(3'd7, 4'd1, 32'h0, 4'd13, 32'h0, 4'd0,
                 32'hA0A0A0A0, 32'h0);
        do_issue(3'd2, 4'd2, 32'hAAAA0000, 4'd0, 32'h0, 4'd12,
                 32'hAAAA0000, 32'h0000FFFF);
        do_issue(3'd1, 4'd3, 32'h0, 4'd12, 32'h12340000, 4'd0,
                 32'h0000FFFF, 32'h12340000);
        cdb(1'b1, 4'd13, 32'hA0A0A0A0);
        tick();
        cdb(1'b0, 4'd0, 32'd0);
        tick();
        chk("age_a_tag", RES_TAG, 1);
        chk("age_reuse_busy", BUSY_COUNT, 2);
        do_issue(3'd0, 4'd4, 32'hFFFF00FF, 4'd0, 32'h0, 4'd12,
                 32'hFFFF00FF, 32'h0000FFFF);
        RES_READY = 1'b0;
        cdb(1'b1, 4'd12, 32'h0000FFFF);
        chk("age_pre_valid", RES_VALID, 0);
        tick();
        cdb(1'b0, 4'd0, 32'd0);
        chk("age_busy3", BUSY_COUNT, 3);
        tick();
        held_data = RES_DATA;
        chk("hold_data_b", held_data, 32'hAAAAFFFF);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", RES_VALID, 1);
            chk("hold_tag", RES_TAG, 2);
            chk("hold_data", RES_DATA, held_data);
            chk("hold_busy", BUSY_COUNT, 2);
            if (i < 4) tick();
        end
        RES_READY = 1'b1;
        tick();
        chk("b2b_tag_c", RES_TAG, 3);
        chk("b2b_valid_c", RES_VALID, 1);
        tick();
        chk("b2b_tag_d", RES_TAG, 4);
        chk("b2b_valid_d", RES_VALID, 1);
        tick();
        chk("b2b_idle", RES_VALID, 0);

        // reset while holding with three busy entries
        RES_READY = 1'b0;
        do_issue(3'd0, 4'd5, 32'h1, 4'd0, 32'h3, 4'd0, 32'h1, 32'h3);
        do_issue(3'd1, 4'd6, 32'h0, 4'd14, 32'h2, 4'd0, 32'h0, 32'h2);
        do_issue(3'd2, 4'd7, 32'h0, 4'd14, 32'h2, 4'd0, 32'h0, 32'h2);
        do_issue(3'd3, 4'd8, 32'h4, 4'd0, 32'h0, 4'd14, 32'h4, 32'h0);
        chk("prerst_valid", RES_VALID, 1);
        chk("prerst_busy", BUSY_COUNT, 3);
        RST = 1'b1;
        RES_READY = 1'b1;
        q.delete();
        tick();
        RST = 1'b0;
        chk("midrst_valid", RES_VALID, 0);
        chk("midrst_busy", BUSY_COUNT, 0);
        chk("midrst_data", RES_DATA, 0);
        cdb(1'b1, 4'd14, 32'hFFFFFFFF);
        tick();
        cdb(1'b0, 4'd0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("postrst_quiet", RES_VALID, 0);
            tick();
        end
        chk("postrst_busy", BUSY_COUNT, 0);
        chk("sb_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
